// File: rtl/mod_calc_pkg.sv
// Shared definitions for the modular-calculation datapath: default
// modulus/exponent, the exponentiation FSM state encoding and width helpers.
package mod_calc_pkg;

    localparam int MOD_DEFAULT = 997;
    localparam int EXP_DEFAULT = 500;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_REDUCE = 3'd1,
        ST_SQR    = 3'd2,
        ST_MUL    = 3'd3,
        ST_DONE   = 3'd4
    } pow_state_e;

    // Number of exponent bits walked by the square-and-multiply loop.
    // EXP=0 still runs one (all-zero) bit so the result is 1.
    function automatic int calc_eb(input int exp_val);
        if (exp_val <= 0) begin
            return 1;
        end
        return $clog2(exp_val + 1);
    endfunction

    // Counter width that never collapses to zero bits.
    function automatic int clog2_min1(input int n);
        if ($clog2(n) < 1) begin
            return 1;
        end
        return $clog2(n);
    endfunction

endpackage

// File: rtl/mod_mul_seq.sv
// Interleaved modular multiplier: p = a*b mod MOD, one multiplier bit per
// cycle, MSB first. The first iteration runs on the start edge, so p is
// final W edges after start and done pulses for one cycle after that.
module mod_mul_seq
    import mod_calc_pkg::*;
#(
    parameter int MOD = MOD_DEFAULT,
    parameter int W   = $clog2(MOD)
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    output logic         done,
    output logic [W-1:0] p
);

    localparam int         CW    = clog2_min1(W + 1);
    localparam logic [W:0] MOD_X = (W + 1)'(MOD);

    logic [W-1:0]  a_q, a_d;
    logic [W-1:0]  b_q, b_d;
    logic [W-1:0]  p_q, p_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          busy_q, busy_d;
    logic          done_q, done_d;

    // One interleaved step; operands are always < MOD so W+1 bits suffice.
    function automatic logic [W-1:0] mod_step(input logic [W-1:0] pv,
                                              input logic [W-1:0] av,
                                              input logic         bt);
        logic [W:0] t;
        t = {pv, 1'b0};
        if (t >= MOD_X) t = t - MOD_X;
        if (bt) t = t + {1'b0, av};
        if (t >= MOD_X) t = t - MOD_X;
        return t[W-1:0];
    endfunction

    // Next-state: load-and-iterate on start, then count remaining bits down.
    always_comb begin
        a_d    = a_q;
        b_d    = b_q;
        p_d    = p_q;
        cnt_d  = cnt_q;
        busy_d = busy_q;
        done_d = 1'b0;
        if (start) begin
            a_d    = a;
            b_d    = b << 1;
            p_d    = mod_step('0, a, b[W-1]);
            cnt_d  = CW'(W - 1);
            busy_d = (W > 1);
            done_d = (W == 1);
        end else if (busy_q) begin
            p_d   = mod_step(p_q, a_q, b_q[W-1]);
            b_d   = b_q << 1;
            cnt_d = cnt_q - 1'b1;
            if (cnt_q == CW'(1)) begin
                busy_d = 1'b0;
                done_d = 1'b1;
            end
        end
    end

    // Register update with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            a_q    <= '0;
            b_q    <= '0;
            p_q    <= '0;
            cnt_q  <= '0;
            busy_q <= 1'b0;
            done_q <= 1'b0;
        end else begin
            a_q    <= a_d;
            b_q    <= b_d;
            p_q    <= p_d;
            cnt_q  <= cnt_d;
            busy_q <= busy_d;
            done_q <= done_d;
        end
    end

    assign done = done_q;
    assign p    = p_q;

endmodule

// File: rtl/mod_pow_seq.sv
// Sequential modular exponentiation z = x^EXP mod MOD with valid/ready on
// both sides. Latency from accept to out_valid is 1 + IN_W + 2*W*EB cycles
// regardless of the operand or exponent bits.
//
// state  | meaning
// -------+-----------------------------------------------------------------
// IDLE   | in_ready=1, waiting for an operand
// REDUCE | shift x in MSB first, r = x mod MOD (IN_W cycles)
// SQR    | acc = acc*acc mod MOD (first cycle only launches the multiply)
// MUL    | t = acc*xr mod MOD, committed to acc when EXP bit j is 1
// DONE   | out_valid=1, z held until out_ready
//
// Each multiply's done cycle launches the next one with the freshly
// committed accumulator, so phases chain back to back without bubbles.
module mod_pow_seq
    import mod_calc_pkg::*;
#(
    parameter int  MOD  = MOD_DEFAULT,
    parameter int  EXP  = EXP_DEFAULT,
    parameter int  IN_W = 24,
    localparam int W    = $clog2(MOD),
    localparam int EB   = calc_eb(EXP)
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [IN_W-1:0] x,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [W-1:0]    z
);

    localparam int            CNTW    = clog2_min1(IN_W);
    localparam int            BW      = clog2_min1(EB);
    localparam logic [W:0]    MOD_X   = (W + 1)'(MOD);
    localparam logic [EB-1:0] EXP_VEC = EB'(EXP);

    pow_state_e      state_q, state_d;
    logic            in_ready_q, in_ready_d;
    logic            out_valid_q, out_valid_d;
    logic [W-1:0]    z_q, z_d;
    logic [IN_W-1:0] x_sh_q, x_sh_d;
    logic [W-1:0]    r_q, r_d;
    logic [CNTW-1:0] red_cnt_q, red_cnt_d;
    logic [W-1:0]    acc_q, acc_d;
    logic [BW-1:0]   bit_idx_q, bit_idx_d;
    logic            first_q, first_d;

    logic [W:0]      r_ext;
    logic [W-1:0]    acc_new;
    logic            exp_bit;
    logic            mul_start;
    logic [W-1:0]    mul_a, mul_b;
    logic            mul_done;
    logic [W-1:0]    mul_p;

    mod_mul_seq #(
        .MOD (MOD),
        .W   (W)
    ) u_mul (
        .clk   (clk),
        .rst   (rst),
        .start (mul_start),
        .a     (mul_a),
        .b     (mul_b),
        .done  (mul_done),
        .p     (mul_p)
    );

    // FSM next-state, datapath updates and multiplier launch control.
    always_comb begin
        state_d     = state_q;
        in_ready_d  = in_ready_q;
        out_valid_d = out_valid_q;
        z_d         = z_q;
        x_sh_d      = x_sh_q;
        r_d         = r_q;
        red_cnt_d   = red_cnt_q;
        acc_d       = acc_q;
        bit_idx_d   = bit_idx_q;
        first_d     = 1'b0;
        mul_start   = 1'b0;
        mul_a       = acc_q;
        mul_b       = acc_q;
        exp_bit     = EXP_VEC[bit_idx_q];
        acc_new     = exp_bit ? mul_p : acc_q;

        r_ext = {r_q, x_sh_q[IN_W-1]};
        if (r_ext >= MOD_X) r_ext = r_ext - MOD_X;

        case (state_q)
            ST_IDLE: begin
                if (in_valid && in_ready_q) begin
                    x_sh_d     = x;
                    r_d        = '0;
                    red_cnt_d  = CNTW'(IN_W - 1);
                    in_ready_d = 1'b0;
                    state_d    = ST_REDUCE;
                end
            end
            ST_REDUCE: begin
                x_sh_d    = x_sh_q << 1;
                r_d       = r_ext[W-1:0];
                red_cnt_d = red_cnt_q - 1'b1;
                if (red_cnt_q == '0) begin
                    acc_d     = W'(1);
                    bit_idx_d = BW'(EB - 1);
                    first_d   = 1'b1;
                    state_d   = ST_SQR;
                end
            end
            ST_SQR: begin
                if (first_q) begin
                    mul_start = 1'b1;
                end else if (mul_done) begin
                    acc_d     = mul_p;
                    mul_start = 1'b1;
                    mul_a     = mul_p;
                    mul_b     = r_q;
                    state_d   = ST_MUL;
                end
            end
            ST_MUL: begin
                if (mul_done) begin
                    acc_d = acc_new;
                    if (bit_idx_q == '0) begin
                        out_valid_d = 1'b1;
                        z_d         = acc_new;
                        state_d     = ST_DONE;
                    end else begin
                        bit_idx_d = bit_idx_q - 1'b1;
                        mul_start = 1'b1;
                        mul_a     = acc_new;
                        mul_b     = acc_new;
                        state_d   = ST_SQR;
                    end
                end
            end
            ST_DONE: begin
                if (out_ready) begin
                    out_valid_d = 1'b0;
                    in_ready_d  = 1'b1;
                    state_d     = ST_IDLE;
                end
            end
            default: begin
                out_valid_d = 1'b0;
                in_ready_d  = 1'b1;
                state_d     = ST_IDLE;
            end
        endcase
    end

    // State and registered outputs; reset aborts any operation in flight.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            z_q         <= '0;
            x_sh_q      <= '0;
            r_q         <= '0;
            red_cnt_q   <= '0;
            acc_q       <= '0;
            bit_idx_q   <= '0;
            first_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            in_ready_q  <= in_ready_d;
            out_valid_q <= out_valid_d;
            z_q         <= z_d;
            x_sh_q      <= x_sh_d;
            r_q         <= r_d;
            red_cnt_q   <= red_cnt_d;
            acc_q       <= acc_d;
            bit_idx_q   <= bit_idx_d;
            first_q     <= first_d;
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign z         = z_q;

endmodule

// File: tb/tb_mod_pow_seq.sv
// Directed bench for mod_pow_seq: default instance (MOD=997, EXP=500) and an
// EXP=0 instance, checked against hand values and a square-and-multiply model.
module tb_mod_pow_seq;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst;
    logic        in_valid, out_ready, in_ready, out_valid;
    logic [23:0] x;
    logic [9:0]  z;
    logic        in_valid0, out_ready0, in_ready0, out_valid0;
    logic [23:0] x0;
    logic [9:0]  z0;

    int n_tests = 0;
    int n_fail  = 0;

    mod_pow_seq #(.MOD(997), .EXP(500), .IN_W(24)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .x         (x),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .z         (z)
    );

    mod_pow_seq #(.MOD(997), .EXP(0), .IN_W(24)) dut0 (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid0),
        .in_ready  (in_ready0),
        .x         (x0),
        .out_valid (out_valid0),
        .out_ready (out_ready0),
        .z         (z0)
    );

    task automatic chk(input string tag, input longint got, input longint exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Right-to-left binary exponentiation with native modulo.
    function automatic longint ref_pow(input longint unsigned xv, input int unsigned e);
        longint unsigned base = xv % 997;
        longint unsigned res  = 1;
        int unsigned     k    = e;
        while (k != 0) begin
            if (k[0]) res = (res * base) % 997;
            base = (base * base) % 997;
            k = k >> 1;
        end
        return longint'(res);
    endfunction

    // Offer one operand, wait (bounded) for out_valid; leaves out_ready alone.
    task automatic do_op(input bit sel, input logic [23:0] xv,
                         output int lat, output int zv, output bit ready_low);
        int w = 0;
        while (((sel ? in_ready0 : in_ready) == 1'b0) && w < 20) begin
            tick();
            w++;
        end
        if (sel) begin
            in_valid0 = 1'b1;
            x0 = xv;
        end else begin
            in_valid = 1'b1;
            x = xv;
        end
        tick();
        in_valid  = 1'b0;
        in_valid0 = 1'b0;
        lat = 0;
        ready_low = 1'b1;
        while (((sel ? out_valid0 : out_valid) == 1'b0) && lat < 600) begin
            if ((sel ? in_ready0 : in_ready) != 1'b0) ready_low = 1'b0;
            tick();
            lat++;
        end
        zv = int'(sel ? z0 : z);
    endtask

    task automatic op_full(input string tag, input bit sel, input logic [23:0] xv,
                           input longint expz, input int explat);
        int lat, zv;
        bit rl;
        if (sel) out_ready0 = 1'b1;
        else     out_ready  = 1'b1;
        do_op(sel, xv, lat, zv, rl);
        chk({tag, "_z"}, zv, expz);
        chk({tag, "_lat"}, lat, explat);
        chk({tag, "_rdy_low"}, rl, 1);
        tick();
        chk({tag, "_ov_after"}, sel ? out_valid0 : out_valid, 0);
        chk({tag, "_rdy_after"}, sel ? in_ready0 : in_ready, 1);
    endtask

    initial begin
        int lat, zv, bad;
        bit rl;
        logic [23:0] rx;

        rst = 1'b1;
        in_valid = 1'b0; in_valid0 = 1'b0;
        x = '0; x0 = '0;
        out_ready = 1'b1; out_ready0 = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;

        chk("rst_in_ready", in_ready, 1);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_z", z, 0);
        chk("rst0_in_ready", in_ready0, 1);
        chk("rst0_out_valid", out_valid0, 0);
        chk("model_x2", ref_pow(2, 500), 993);

        op_full("x2", 0, 24'd2, 993, 205);
        op_full("x997", 0, 24'd997, 0, 205);
        op_full("x1994", 0, 24'd1994, 0, 205);
        op_full("x998", 0, 24'd998, 1, 205);
        op_full("x996", 0, 24'd996, 1, 205);
        op_full("xmax", 0, 24'hFFFFFF, ref_pow(696, 500), 205);

        for (int i = 0; i < 200; i++) begin
            rx = 24'($urandom());
            op_full("rnd", 0, rx, ref_pow(64'(rx), 500), 205);
        end

        op_full("e0_x0", 1, 24'd0, 1, 45);
        op_full("e0_x123", 1, 24'd123, 1, 45);

        // Consumer stalls: result must hold, new operands must be ignored.
        out_ready = 1'b0;
        do_op(0, 24'd2, lat, zv, rl);
        chk("stall_z", zv, 993);
        chk("stall_lat", lat, 205);
        bad = 0;
        for (int i = 0; i < 50; i++) begin
            in_valid = i[0];
            x = 24'd5;
            tick();
            if (out_valid !== 1'b1 || z !== 10'd993 || in_ready !== 1'b0) bad++;
        end
        in_valid = 1'b0;
        chk("stall_stable", bad, 0);
        out_ready = 1'b1;
        tick();
        chk("release_ov", out_valid, 0);
        chk("release_rdy", in_ready, 1);
        chk("release_z_held", z, 993);
        tick();
        chk("release_single", out_valid, 0);
        chk("release_idle", in_ready, 1);
        op_full("post_stall", 0, 24'd3, ref_pow(3, 500), 205);

        // Abort mid-operation with reset on the 100th edge after accept.
        in_valid = 1'b1;
        x = 24'd2;
        tick();
        in_valid = 1'b0;
        chk("abort_busy", in_ready, 0);
        repeat (98) tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("abort_ov", out_valid, 0);
        chk("abort_z", z, 0);
        chk("abort_rdy", in_ready, 1);
        op_full("post_rst", 0, 24'd996, 1, 205);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/mod_pow_seq.md
Name: mod_pow_seq

Overview:
- Sequential modular exponentiation unit: computes z = x^EXP mod MOD for one operand at a time.
- Parametrised in modulus, exponent and input width; replaces the per-exponent combinational lookup slices used in the modular-calculation datapath.
- Sits between the operand source and the residue accumulator; valid/ready handshakes on both sides.

Parameters:
- MOD, 997, modulus; must satisfy 2 <= MOD < 2**W.
- EXP, 500, exponent; EXP >= 0.
- IN_W, 24, width of the input operand x.
- W, $clog2(MOD), residue width (derived localparam, 10 for defaults).
- EB, max(1, $clog2(EXP+1)), number of exponent bits processed (derived, 9 for defaults).

Ports:
- clk  in  1  clock.
- rst  in  1  reset, synchronous, active-high.
- in_valid  in  1  operand x is valid.
- in_ready  out  1  unit can accept an operand.
- x  in  IN_W  operand, unsigned.
- out_valid  out  1  result z is valid.
- out_ready  in  1  consumer accepts z.
- z  out  W  result x^EXP mod MOD, in the range 0..MOD-1.

Behaviour:
- One clock domain (clk). Reset is synchronous and active-high (rst).
- Reset values: in_ready=1, out_valid=0, z=0, FSM=IDLE. rst asserted in any state aborts the operation on the next edge; no partial result is ever presented.
- FSM states:
  - IDLE: in_ready=1. in_valid&&in_ready latches x and moves to REDUCE.
  - REDUCE: IN_W cycles, MSB first: r = 2r + bit; if r >= MOD then r -= MOD. Result is xr = x mod MOD.
  - SQR: W cycles; acc = acc*acc mod MOD.
  - MUL: W cycles; t = acc*xr mod MOD. t is committed to acc only if EXP bit j is 1; the step always runs, so latency is constant.
  - DONE: out_valid=1, z held stable until out_ready, then return to IDLE.
- acc is initialised to 1 on entry to the first SQR. Exponent bits are processed left to right, j = EB-1 down to 0, one SQR->MUL pair per bit.
- Modular multiply a*b, interleaved, one iteration per cycle, bit i = W-1..0: p = 2p; if p >= MOD then p -= MOD; if b[i] then p += a; if p >= MOD then p -= MOD. Intermediates are W+1 bits wide; no full product is formed.
- Latency: out_valid rises exactly LAT = 1 + IN_W + 2*W*EB cycles after the accept edge (205 for defaults). This is data-independent.
- in_ready=0 in every state except IDLE. No overlap: the next accept is possible at the earliest one cycle after the output handshake.
- EXP=0: every bit is 0, so z=1 for every x, including x ≡ 0 (0^0 defined as 1).
- x ≡ 0 mod MOD with EXP>0: z=0.
- out_ready held low: z and out_valid stay stable indefinitely. in_valid arriving in any non-IDLE state is ignored (not accepted).

Decomposition:
- Shared package mod_calc_pkg holds:
  - default MOD/EXP constants;
  - the FSM state enum (IDLE, REDUCE, SQR, MUL, DONE);
  - a function computing EB.
- One sub-module, mod_mul_seq (parameters MOD, W):
  - start/a/b in, done/p out;
  - W-cycle interleaved multiply;
  - used for both SQR and MUL.
- The REDUCE loop stays in the top level.

Test Plan:
- Reset, then x=2 with defaults -> z=993 (=-4 mod 997) exactly 205 cycles after accept; in_ready=0 throughout.
- x=997, x=1994, then x=998 back-to-back with out_ready=1 -> z=0, 0, 1. in_ready returns one cycle after each output handshake.
- x=996 -> z=1. x=16777215 (reduces to 696) -> z matches reference model of 696^500 mod 997. Also 200 random x values compared against the model.
- EXP=0 override: x=0 -> z=1; x=123 -> z=1. Latency = 1+IN_W+2W = 45.
- out_ready held low 50 cycles after out_valid -> z and out_valid stable, in_valid pulses ignored. Release -> single transfer, then IDLE.
- rst asserted in cycle 100 of an operation -> next cycle: out_valid=0, z=0, in_ready=1. A new operand then completes with the correct result.
